// File: rtl/video_timing_gen_pkg.sv
// Shared 640x480@60 raster defaults, derived totals and the generator FSM encoding.
package video_timing_gen_pkg;

   localparam int cHActive = 640;
   localparam int cHFront  = 16;
   localparam int cHSync   = 96;
   localparam int cHBack   = 48;
   localparam int cVActive = 480;
   localparam int cVFront  = 10;
   localparam int cVSync   = 2;
   localparam int cVBack   = 33;

   localparam int cHTotal = cHActive + cHFront + cHSync + cHBack;
   localparam int cVTotal = cVActive + cVFront + cVSync + cVBack;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } vtgState_t;

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter with load, terminal count and
// active/sync region decode of the current count.
module vtg_axis_counter
   import video_timing_gen_pkg::*;
#(
   parameter int pWidth     = 12,
   parameter int pTotal     = cHTotal,
   parameter int pActive    = cHActive,
   parameter int pSyncStart = cHActive + cHFront,
   parameter int pSyncEnd   = cHActive + cHFront + cHSync
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              clear,
   input  logic              load,
   input  logic [pWidth-1:0] loadVal,
   input  logic              inc,
   output logic [pWidth-1:0] cnt,
   output logic              tc,
   output logic              active,
   output logic              sync
);

   always_ff @(posedge clk) begin
      if (!rstN || clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= loadVal;
      end else if (inc) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

   assign tc     = (cnt == pWidth'(pTotal - 1));
   assign active = (cnt < pWidth'(pActive));
   assign sync   = (cnt >= pWidth'(pSyncStart)) && (cnt < pWidth'(pSyncEnd));

endmodule

// File: rtl/video_timing_gen.sv
// 640x480@60 raster timing generator: H/V counters, IDLE/RUN control and
// registered sync, DE, position, strobe and look-ahead request outputs.
module video_timing_gen
   import video_timing_gen_pkg::*;
#(
   parameter int   pHActive  = cHActive,
   parameter int   pHFront   = cHFront,
   parameter int   pHSync    = cHSync,
   parameter int   pHBack    = cHBack,
   parameter int   pVActive  = cVActive,
   parameter int   pVFront   = cVFront,
   parameter int   pVSync    = cVSync,
   parameter int   pVBack    = cVBack,
   parameter logic pHSyncPol = 1'b0,
   parameter logic pVSyncPol = 1'b0,
   parameter int   pPre      = 2
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iEnable,
   output logic        oHSync,
   output logic        oVSync,
   output logic        oDe,
   output logic        oReq,
   output logic [11:0] oHPos,
   output logic [10:0] oVPos,
   output logic        oLineStart,
   output logic        oFrameStart,
   output logic        oVBlank
);

   localparam int HTotal = pHActive + pHFront + pHSync + pHBack;
   localparam int VTotal = pVActive + pVFront + pVSync + pVBack;

   localparam logic [11:0] hLoad = 12'(HTotal - pPre);
   localparam logic [10:0] vLoad = 11'(VTotal - 1);

   vtgState_t   state;
   logic        startRun;
   logic        stopRun;
   logic        running;
   logic [11:0] hCnt;
   logic [10:0] vCnt;
   logic        hTc, vTc;
   logic        hActive, vActive;
   logic        hSyncAct, vSyncAct;
   logic [12:0] hAheadSum;
   logic [11:0] hAhead;
   logic [10:0] vAhead;
   logic        reqNext;

   assign startRun = (state == IDLE) && iEnable;
   assign stopRun  = (state == RUN) && !iEnable;
   assign running  = (state == RUN) && iEnable;

   vtg_axis_counter #(
      .pWidth    (12),
      .pTotal    (HTotal),
      .pActive   (pHActive),
      .pSyncStart(pHActive + pHFront),
      .pSyncEnd  (pHActive + pHFront + pHSync)
   ) uHCounter (
      .clk    (iClk),
      .rstN   (iRst),
      .clear  (stopRun),
      .load   (startRun),
      .loadVal(hLoad),
      .inc    (running),
      .cnt    (hCnt),
      .tc     (hTc),
      .active (hActive),
      .sync   (hSyncAct)
   );

   // V advances once per line; its sync region spans whole lines so it starts at hcnt=0.
   vtg_axis_counter #(
      .pWidth    (11),
      .pTotal    (VTotal),
      .pActive   (pVActive),
      .pSyncStart(pVActive + pVFront),
      .pSyncEnd  (pVActive + pVFront + pVSync)
   ) uVCounter (
      .clk    (iClk),
      .rstN   (iRst),
      .clear  (stopRun),
      .load   (startRun),
      .loadVal(vLoad),
      .inc    (running && hTc),
      .cnt    (vCnt),
      .tc     (vTc),
      .active (vActive),
      .sync   (vSyncAct)
   );

   // Position pPre clocks ahead; a single subtract suffices since pPre <= HTotal-pHActive.
   always_comb begin
      hAheadSum = {1'b0, hCnt} + 13'(pPre);
      hAhead    = hAheadSum[11:0];
      vAhead    = vCnt;
      if (hAheadSum >= 13'(HTotal)) begin
         hAhead = 12'(hAheadSum - 13'(HTotal));
         vAhead = vTc ? '0 : vCnt + 1'b1;
      end
      reqNext = (hAhead < 12'(pHActive)) && (vAhead < 11'(pVActive));
   end

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         state       <= IDLE;
         oHSync      <= !pHSyncPol;
         oVSync      <= !pVSyncPol;
         oDe         <= 1'b0;
         oReq        <= 1'b0;
         oHPos       <= '0;
         oVPos       <= '0;
         oLineStart  <= 1'b0;
         oFrameStart <= 1'b0;
         oVBlank     <= 1'b0;
      end else begin
         oHSync      <= !pHSyncPol;
         oVSync      <= !pVSyncPol;
         oDe         <= 1'b0;
         oReq        <= 1'b0;
         oHPos       <= '0;
         oVPos       <= '0;
         oLineStart  <= 1'b0;
         oFrameStart <= 1'b0;
         oVBlank     <= 1'b0;
         case (state)
            IDLE: begin
               if (iEnable) state <= RUN;
            end
            RUN: begin
               if (!iEnable) begin
                  state <= IDLE;
               end else begin
                  oHSync      <= hSyncAct ? pHSyncPol : !pHSyncPol;
                  oVSync      <= vSyncAct ? pVSyncPol : !pVSyncPol;
                  oDe         <= hActive && vActive;
                  oReq        <= reqNext;
                  oHPos       <= (hActive && vActive) ? hCnt : '0;
                  oVPos       <= (hActive && vActive) ? vCnt : '0;
                  oLineStart  <= vActive && (hCnt == '0);
                  oFrameStart <= (hCnt == '0) && (vCnt == '0);
                  oVBlank     <= !vActive;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen; full 800-clock lines, shortened 25-line frame.
module tb_video_timing_gen;

   localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = HA + HF + HS + HB;
   localparam int VA = 16, VF = 3, VS = 2, VB = 4, VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        iClk = 1'b0;
   logic        iRst = 1'b0;
   logic        iEnable = 1'b0;
   logic        oHSync, oVSync, oDe, oReq, oLineStart, oFrameStart, oVBlank;
   logic [11:0] oHPos;
   logic [10:0] oVPos;

   int nChecks = 0;
   int nFails = 0;

   logic [29:0] outVec;
   logic [29:0] idleVec;
   assign outVec  = {oHSync, oVSync, oDe, oReq, oLineStart, oFrameStart, oVBlank, oHPos, oVPos};
   assign idleVec = {1'b1, 1'b1, 5'b00000, 12'd0, 11'd0};

   always #20 iClk = ~iClk;

   video_timing_gen #(
      .pHActive(HA), .pHFront(HF), .pHSync(HS), .pHBack(HB),
      .pVActive(VA), .pVFront(VF), .pVSync(VS), .pVBack(VB),
      .pHSyncPol(1'b0), .pVSyncPol(1'b0), .pPre(2)
   ) dut (
      .iClk(iClk), .iRst(iRst), .iEnable(iEnable),
      .oHSync(oHSync), .oVSync(oVSync), .oDe(oDe), .oReq(oReq),
      .oHPos(oHPos), .oVPos(oVPos), .oLineStart(oLineStart),
      .oFrameStart(oFrameStart), .oVBlank(oVBlank)
   );

   task automatic test_reset();
      iRst = 1'b0;
      iEnable = 1'b1;
      repeat (3) @(negedge iClk);
      nChecks++;
      if (outVec !== idleVec) begin
         nFails++;
         $display("FAIL reset_hold: outputs %h, required %h", outVec, idleVec);
      end
   endtask

   task automatic test_enable();
      int hi, lo;
      iRst = 1'b1;
      iEnable = 1'b0;
      repeat (2) @(negedge iClk);
      nChecks++;
      if (outVec !== idleVec) begin
         nFails++;
         $display("FAIL idle_disabled: outputs %h, required %h", outVec, idleVec);
      end
      iEnable = 1'b1;
      @(negedge iClk);
      nChecks++;
      if (oReq !== 1'b0) begin
         nFails++;
         $display("FAIL enable_req_e0: oReq %b, required 0", oReq);
      end
      @(negedge iClk);
      nChecks++;
      if ({oReq, oDe} !== 2'b10) begin
         nFails++;
         $display("FAIL enable_req_e1: oReq/oDe %b, required 10", {oReq, oDe});
      end
      @(negedge iClk);
      nChecks++;
      if ({oReq, oDe} !== 2'b10) begin
         nFails++;
         $display("FAIL enable_e2: oReq/oDe %b, required 10", {oReq, oDe});
      end
      @(negedge iClk);
      nChecks++;
      if ({oDe, oFrameStart, oLineStart, oVBlank, oHPos, oVPos} !== {4'b1110, 12'd0, 11'd0}) begin
         nFails++;
         $display("FAIL enable_first_pixel: de/fs/ls/vb %b pos %0d,%0d, required 1110 pos 0,0",
                  {oDe, oFrameStart, oLineStart, oVBlank}, oHPos, oVPos);
      end
      hi = 1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge iClk);
         if (!oDe) break;
         hi++;
      end
      nChecks++;
      if (hi != HA) begin
         nFails++;
         $display("FAIL de_high_len: %0d clocks, required %0d", hi, HA);
      end
      lo = 1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge iClk);
         if (oDe) break;
         lo++;
      end
      nChecks++;
      if (lo != HT - HA) begin
         nFails++;
         $display("FAIL de_low_len: %0d clocks, required %0d", lo, HT - HA);
      end
      nChecks++;
      if ({oLineStart, oFrameStart, oHPos, oVPos} !== {2'b10, 12'd0, 11'd1}) begin
         nFails++;
         $display("FAIL second_line_start: ls/fs %b pos %0d,%0d, required 10 pos 0,1",
                  {oLineStart, oFrameStart}, oHPos, oVPos);
      end
   endtask

   task automatic test_free_run();
      int frames = 0, lineStarts = 0, lastFs = 0, mx = 0, my = 0, nHist = 0;
      int hLow = 0, vLow = 0, hRuns = 0, vRuns = 0;
      int errReq = 0, errModel = 0, errH = 0, errV = 0, errPeriod = 0, errLines = 0;
      logic r1 = 1'b0, r2 = 1'b0, synced = 1'b0;
      logic ed, es, eh, ev;
      logic [28:0] expV, actV;
      for (int cyc = 0; cyc < 3 * FRAME + 1000; cyc++) begin
         @(negedge iClk);
         if (nHist >= 2 && oDe !== r2) errReq++;
         r2 = r1;
         r1 = oReq;
         nHist++;
         if (oFrameStart) begin
            if (synced) begin
               if (cyc - lastFs != FRAME) errPeriod++;
               if (lineStarts != VA) errLines++;
            end
            synced = 1'b1;
            frames++;
            lastFs = cyc;
            lineStarts = 0;
            mx = 0;
            my = 0;
         end else if (synced) begin
            mx++;
            if (mx == HT) begin
               mx = 0;
               my = (my == VT - 1) ? 0 : my + 1;
            end
         end
         if (oLineStart) lineStarts++;
         if (synced) begin
            ed = (mx < HA) && (my < VA);
            eh = !((mx >= HA + HF) && (mx < HA + HF + HS));
            ev = !((my >= VA + VF) && (my < VA + VF + VS));
            es = (mx == 0) && (my == 0);
            expV = {eh, ev, ed, ed && (mx == 0), es, (my >= VA),
                    ed ? 12'(mx) : 12'd0, ed ? 11'(my) : 11'd0};
            actV = {oHSync, oVSync, oDe, oLineStart, oFrameStart, oVBlank, oHPos, oVPos};
            if (actV !== expV) begin
               if (errModel == 0)
                  $display("FAIL raster_model: at x=%0d y=%0d outputs %h, required %h", mx, my, actV, expV);
               errModel++;
            end
         end
         if (!oHSync) hLow++;
         else if (hLow != 0) begin
            if (hLow != HS) errH++;
            hRuns++;
            hLow = 0;
         end
         if (!oVSync) vLow++;
         else if (vLow != 0) begin
            if (vLow != VS * HT) errV++;
            vRuns++;
            vLow = 0;
         end
         if (frames == 3) break;
      end
      nChecks++;
      if (frames != 3) begin
         nFails++;
         $display("FAIL frame_count: saw %0d frame starts within budget, required 3", frames);
      end
      nChecks++;
      if (errReq != 0) begin
         nFails++;
         $display("FAIL req_lead: %0d clocks where oDe differed from oReq two clocks earlier, required 0", errReq);
      end
      nChecks++;
      if (errModel != 0) begin
         nFails++;
         $display("FAIL raster_total: %0d mismatching clocks, required 0", errModel);
      end
      nChecks++;
      if (errH != 0 || hRuns < 2 * VT) begin
         nFails++;
         $display("FAIL hsync_width: %0d bad of %0d pulses, required 0 bad of >=%0d", errH, hRuns, 2 * VT);
      end
      nChecks++;
      if (errV != 0 || vRuns < 2) begin
         nFails++;
         $display("FAIL vsync_width: %0d bad of %0d pulses, required 0 bad of >=2", errV, vRuns);
      end
      nChecks++;
      if (errPeriod != 0) begin
         nFails++;
         $display("FAIL frame_period: %0d bad periods, required 0 (period %0d)", errPeriod, FRAME);
      end
      nChecks++;
      if (errLines != 0) begin
         nFails++;
         $display("FAIL line_starts: %0d frames with wrong count, required 0 (count %0d)", errLines, VA);
      end
   endtask

   task automatic test_disable();
      bit found = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge iClk);
         if (oDe && oHPos == 12'd300 && oVPos == 11'd10) begin
            found = 1;
            break;
         end
      end
      nChecks++;
      if (!found) begin
         nFails++;
         $display("FAIL disable_wait: position 300,10 not reached, last %0d,%0d", oHPos, oVPos);
      end
      iEnable = 1'b0;
      @(negedge iClk);
      nChecks++;
      if (outVec !== idleVec) begin
         nFails++;
         $display("FAIL disable_idle: outputs %h, required %h", outVec, idleVec);
      end
      repeat (4) @(negedge iClk);
      nChecks++;
      if (outVec !== idleVec) begin
         nFails++;
         $display("FAIL disable_hold: outputs %h, required %h", outVec, idleVec);
      end
      iEnable = 1'b1;
      @(negedge iClk);
      nChecks++;
      if (oReq !== 1'b0) begin
         nFails++;
         $display("FAIL reenable_req_e0: oReq %b, required 0", oReq);
      end
      @(negedge iClk);
      nChecks++;
      if ({oReq, oDe} !== 2'b10) begin
         nFails++;
         $display("FAIL reenable_req_e1: oReq/oDe %b, required 10", {oReq, oDe});
      end
      @(negedge iClk);
      @(negedge iClk);
      nChecks++;
      if ({oDe, oFrameStart, oLineStart, oHPos, oVPos} !== {3'b111, 12'd0, 11'd0}) begin
         nFails++;
         $display("FAIL reenable_first_pixel: de/fs/ls %b pos %0d,%0d, required 111 pos 0,0",
                  {oDe, oFrameStart, oLineStart}, oHPos, oVPos);
      end
   endtask

   task automatic test_reset_mid_sync();
      bit found = 0;
      for (int i = 0; i < 2 * HT; i++) begin
         @(negedge iClk);
         if (!oHSync) begin
            found = 1;
            break;
         end
      end
      nChecks++;
      if (!found) begin
         nFails++;
         $display("FAIL reset_sync_wait: oHSync never went low, last %b", oHSync);
      end
      repeat (10) @(negedge iClk);
      iRst = 1'b0;
      @(negedge iClk);
      nChecks++;
      if (outVec !== idleVec) begin
         nFails++;
         $display("FAIL reset_mid_sync: outputs %h, required %h", outVec, idleVec);
      end
      @(negedge iClk);
      iRst = 1'b1;
      @(negedge iClk);
      nChecks++;
      if ({oReq, oDe, oHSync} !== 3'b001) begin
         nFails++;
         $display("FAIL restart_e0: oReq/oDe/oHSync %b, required 001", {oReq, oDe, oHSync});
      end
      @(negedge iClk);
      nChecks++;
      if ({oReq, oDe} !== 2'b10) begin
         nFails++;
         $display("FAIL restart_req_e1: oReq/oDe %b, required 10", {oReq, oDe});
      end
      @(negedge iClk);
      @(negedge iClk);
      nChecks++;
      if ({oDe, oFrameStart, oHPos, oVPos} !== {2'b11, 12'd0, 11'd0}) begin
         nFails++;
         $display("FAIL restart_first_pixel: de/fs %b pos %0d,%0d, required 11 pos 0,0",
                  {oDe, oFrameStart}, oHPos, oVPos);
      end
   endtask

   initial begin
      test_reset();
      test_enable();
      test_free_run();
      test_disable();
      test_reset_mid_sync();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
